alarm_trigger: RTL and testbench

//   Reads the stored alarm time (BCD digits from the alarm-setting counter) and the running clock time.

---
 rtl/alarm_pkg.sv | 27 ++
 rtl/bcd_time_match.sv | 14 +
 rtl/alarm_trigger.sv | 137 +++++++++++++
 tb/tb_alarm_trigger.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm trigger: state encoding, BCD digit widths
// and the packed time bundle compared by bcd_time_match.
package alarm_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RINGING = 2'd1;
   localparam logic [1:0] ST_SNOOZE  = 2'd2;

   localparam int HT_W = 2;
   localparam int HU_W = 4;
   localparam int MT_W = 3;
   localparam int MU_W = 4;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      RINGING = ST_RINGING,
      SNOOZE  = ST_SNOOZE
   } state_e;

   typedef struct packed {
      logic [HT_W-1:0] ht;
      logic [HU_W-1:0] hu;
      logic [MT_W-1:0] mt;
      logic [MU_W-1:0] mu;
   } bcd_time_t;

endpackage

// File: rtl/bcd_time_match.sv
// Pure digit-by-digit compare of two hh:mm BCD bundles. Invalid BCD digits
// are compared bitwise, no correction.
module bcd_time_match
   import alarm_pkg::*;
(
   input  bcd_time_t time_a,
   input  bcd_time_t time_b,
   output logic      match
);

   assign match = (time_a.ht == time_b.ht) && (time_a.hu == time_b.hu) &&
                  (time_a.mt == time_b.mt) && (time_a.mu == time_b.mu);

endmodule

// File: rtl/alarm_trigger.sv
// Fires the buzzer/LED on the rising edge of time==alarm and silences it on
// dismiss, disarm or timeout. Snooze is compiled in with ALARM_SNOOZE_EN.
module alarm_trigger
   import alarm_pkg::*;
#(
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_SECONDS = 300
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sec_tick,
   input  logic            alarm_enable,
   input  logic            dismiss,
   input  logic            snooze,
   input  logic [HT_W-1:0] clk_hours_tenth,
   input  logic [HU_W-1:0] clk_hours_units,
   input  logic [MT_W-1:0] clk_minutes_tenth,
   input  logic [MU_W-1:0] clk_minutes_units,
   input  logic [HT_W-1:0] al_hours_tenth,
   input  logic [HU_W-1:0] al_hours_units,
   input  logic [MT_W-1:0] al_minutes_tenth,
   input  logic [MU_W-1:0] al_minutes_units,
   output logic            alarm_on,
   output logic            alarm_led,
   output logic            ringing
);

   localparam logic [7:0] RING_TC = 8'(RING_SECONDS);

   bcd_time_t  clk_time, al_time;
   logic       match, match_q, match_rise;
   state_e     state, state_nxt;
   logic [7:0] ring_cnt, ring_cnt_nxt;
   logic       blink, blink_nxt;
   logic       snz_req;

   assign clk_time = {clk_hours_tenth, clk_hours_units, clk_minutes_tenth, clk_minutes_units};
   assign al_time  = {al_hours_tenth, al_hours_units, al_minutes_tenth, al_minutes_units};

   bcd_time_match u_match (
      .time_a (clk_time),
      .time_b (al_time),
      .match  (match)
   );

   // Only the edge fires, so a dismissed alarm stays quiet for the rest of the minute.
   assign match_rise = match & ~match_q;

`ifdef ALARM_SNOOZE_EN
   localparam logic [9:0] SNZ_TC = 10'(SNOOZE_SECONDS);
   logic [9:0] snz_cnt, snz_cnt_nxt;
   assign snz_req = snooze;
`else
   logic unused_snooze;
   assign snz_req       = 1'b0;
   assign unused_snooze = ^{snooze, 10'(SNOOZE_SECONDS)};
`endif

   always_comb begin
      state_nxt    = state;
      ring_cnt_nxt = ring_cnt;
      blink_nxt    = blink;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_nxt  = snz_cnt;
`endif
      if (!alarm_enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (match_rise && !dismiss && !snz_req) begin
                  state_nxt    = RINGING;
                  ring_cnt_nxt = '0;
                  blink_nxt    = 1'b1;
               end
            end
            RINGING: begin
               if (dismiss) begin
                  state_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
               end else if (snz_req) begin
                  state_nxt   = SNOOZE;
                  snz_cnt_nxt = '0;
`endif
               end else if (sec_tick) begin
                  blink_nxt = ~blink;
                  if (ring_cnt != RING_TC) ring_cnt_nxt = ring_cnt + 8'd1;
                  if (ring_cnt_nxt == RING_TC) state_nxt = IDLE;
               end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
               if (dismiss) begin
                  state_nxt = IDLE;
               end else if (sec_tick) begin
                  if (snz_cnt != SNZ_TC) snz_cnt_nxt = snz_cnt + 10'd1;
                  if (snz_cnt_nxt == SNZ_TC) begin
                     state_nxt    = RINGING;
                     ring_cnt_nxt = '0;
                     blink_nxt    = 1'b1;
                  end
               end
            end
`endif
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ring_cnt  <= '0;
         blink     <= 1'b0;
         match_q   <= 1'b0;
         alarm_on  <= 1'b0;
         alarm_led <= 1'b0;
         ringing   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         snz_cnt   <= '0;
`endif
      end else begin
         state     <= state_nxt;
         ring_cnt  <= ring_cnt_nxt;
         blink     <= blink_nxt;
         match_q   <= match;
         // Outputs follow the registered state, one clk behind it.
         alarm_on  <= (state == RINGING);
         ringing   <= (state == RINGING);
         alarm_led <= (state == RINGING) ? blink : (state == SNOOZE);
`ifdef ALARM_SNOOZE_EN
         snz_cnt   <= snz_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger: directed scenarios plus random stimulus checked
// against a per-clock behavioural model of the alarm rules.
`timescale 1ns/1ps
module tb_alarm_trigger;

   localparam int RS = 60;
   localparam int SS = 3;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ_EN = 1'b1;
`else
   localparam bit SNZ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1, sec_tick = 1'b0, alarm_enable = 1'b0, dismiss = 1'b0, snooze = 1'b0;
   logic [1:0] c_ht = '0, a_ht = '0;
   logic [3:0] c_hu = '0, a_hu = '0;
   logic [2:0] c_mt = '0, a_mt = '0;
   logic [3:0] c_mu = '0, a_mu = '0;
   logic alarm_on, alarm_led, ringing;

   int checks = 0, failures = 0;

   // Model: mode 0 idle, 1 ringing, 2 snoozing; seconds spent in the mode.
   int m_mode = 0, m_rang = 0, m_snzd = 0;
   bit m_prev_match = 1'b0;
   bit e_on, e_led, e_ring;

   always #5 clk = ~clk;

   alarm_trigger #(.RING_SECONDS(RS), .SNOOZE_SECONDS(SS)) dut (
      .clk(clk), .rst(rst), .sec_tick(sec_tick), .alarm_enable(alarm_enable),
      .dismiss(dismiss), .snooze(snooze),
      .clk_hours_tenth(c_ht), .clk_hours_units(c_hu),
      .clk_minutes_tenth(c_mt), .clk_minutes_units(c_mu),
      .al_hours_tenth(a_ht), .al_hours_units(a_hu),
      .al_minutes_tenth(a_mt), .al_minutes_units(a_mu),
      .alarm_on(alarm_on), .alarm_led(alarm_led), .ringing(ringing)
   );

   task automatic set_clk(input int h, input int m);
      c_ht = 2'(h / 10); c_hu = 4'(h % 10); c_mt = 3'(m / 10); c_mu = 4'(m % 10);
   endtask

   task automatic set_al(input int h, input int m);
      a_ht = 2'(h / 10); a_hu = 4'(h % 10); a_mt = 3'(m / 10); a_mu = 4'(m % 10);
   endtask

   // Advance model and DUT by one clock; outputs after the edge reflect the mode before it.
   task automatic step();
      bit now_match, fire;
      now_match = ({c_ht, c_hu, c_mt, c_mu} == {a_ht, a_hu, a_mt, a_mu});
      fire = now_match && !m_prev_match;
      if (rst) begin
         e_on = 0; e_led = 0; e_ring = 0;
         m_mode = 0; m_rang = 0; m_snzd = 0; m_prev_match = 0;
      end else begin
         e_on   = (m_mode == 1);
         e_ring = (m_mode == 1);
         e_led  = (m_mode == 1) ? (m_rang % 2 == 0) : (m_mode == 2);
         m_prev_match = now_match;
         if (!alarm_enable) m_mode = 0;
         else if (m_mode == 0) begin
            if (fire && !dismiss && !(SNZ_EN && snooze)) begin m_mode = 1; m_rang = 0; end
         end else if (m_mode == 1) begin
            if (dismiss) m_mode = 0;
            else if (SNZ_EN && snooze) begin m_mode = 2; m_snzd = 0; end
            else if (sec_tick) begin m_rang++; if (m_rang == RS) m_mode = 0; end
         end else begin
            if (dismiss) m_mode = 0;
            else if (sec_tick) begin m_snzd++; if (m_snzd == SS) begin m_mode = 1; m_rang = 0; end end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic tick_n(input int n, input int gap);
      repeat (n) begin
         sec_tick = 1; step(); sec_tick = 0;
         repeat (gap) step();
      end
   endtask

   // Leave the alarm minute and come back to it, producing a fresh match edge.
   task automatic refire();
      set_clk(7, 31); step();
      set_clk(7, 30); step(); step();
   endtask

   task automatic test_reset();
      set_al(7, 30); set_clk(7, 29);
      rst = 1; step(); step();
      checks++; if ({alarm_on, alarm_led, ringing} !== 3'b000) begin failures++;
         $display("FAIL reset_outs: got %b want 000", {alarm_on, alarm_led, ringing}); end
      rst = 0; step();
      checks++; if ({alarm_on, alarm_led, ringing} !== {e_on, e_led, e_ring}) begin failures++;
         $display("FAIL reset_release: got %b want %b", {alarm_on, alarm_led, ringing}, {e_on, e_led, e_ring}); end
   endtask

   task automatic test_fire();
      alarm_enable = 1; repeat (3) step();
      set_clk(7, 30); step();
      checks++; if (alarm_on !== 1'b0) begin failures++;
         $display("FAIL fire_latency1: got %b want 0", alarm_on); end
      step();
      checks++; if ({alarm_on, alarm_led, ringing} !== 3'b111) begin failures++;
         $display("FAIL fire_latency2: got %b want 111", {alarm_on, alarm_led, ringing}); end
      sec_tick = 1; step(); sec_tick = 0;
      checks++; if (alarm_led !== 1'b1) begin failures++;
         $display("FAIL led_lag: got %b want 1", alarm_led); end
      step();
      checks++; if (alarm_led !== 1'b0 || alarm_led !== e_led) begin failures++;
         $display("FAIL led_toggle: got %b want 0 (model %b)", alarm_led, e_led); end
   endtask

   task automatic test_timeout();
      tick_n(RS - 2, 2);
      sec_tick = 1; step(); sec_tick = 0;
      checks++; if (alarm_on !== 1'b1) begin failures++;
         $display("FAIL timeout_last_tick: got %b want 1", alarm_on); end
      step();
      checks++; if ({alarm_on, ringing} !== 2'b00 || alarm_on !== e_on) begin failures++;
         $display("FAIL timeout_off: got %b want 00", {alarm_on, ringing}); end
      tick_n(20, 1);
      checks++; if ({alarm_on, alarm_led, ringing} !== 3'b000) begin failures++;
         $display("FAIL timeout_no_refire: got %b want 000", {alarm_on, alarm_led, ringing}); end
   endtask

   task automatic test_dismiss();
      refire();
      checks++; if (alarm_on !== 1'b1) begin failures++;
         $display("FAIL dismiss_refire: got %b want 1", alarm_on); end
      tick_n(4, 1);
      dismiss = 1; sec_tick = 1; step(); dismiss = 0; sec_tick = 0;
      checks++; if (alarm_on !== 1'b1) begin failures++;
         $display("FAIL dismiss_lag: got %b want 1", alarm_on); end
      step();
      checks++; if ({alarm_on, alarm_led, ringing} !== 3'b000) begin failures++;
         $display("FAIL dismiss_off: got %b want 000", {alarm_on, alarm_led, ringing}); end
      tick_n(100, 1);
      checks++; if ({alarm_on, ringing} !== 2'b00 || {alarm_on, ringing} !== {e_on, e_ring}) begin failures++;
         $display("FAIL dismiss_same_minute: got %b want 00", {alarm_on, ringing}); end
   endtask

   task automatic test_enable();
      refire();
      alarm_enable = 0; step();
      checks++; if (alarm_on !== 1'b1) begin failures++;
         $display("FAIL disarm_lag: got %b want 1", alarm_on); end
      step();
      checks++; if ({alarm_on, alarm_led, ringing} !== 3'b000) begin failures++;
         $display("FAIL disarm_off: got %b want 000", {alarm_on, alarm_led, ringing}); end
      alarm_enable = 1; repeat (5) step();
      checks++; if (alarm_on !== 1'b0) begin failures++;
         $display("FAIL rearm_no_edge: got %b want 0", alarm_on); end
      refire();
      checks++; if ({alarm_on, ringing} !== 2'b11 || alarm_on !== e_on) begin failures++;
         $display("FAIL rearm_next_match: got %b want 11", {alarm_on, ringing}); end
      dismiss = 1; step(); dismiss = 0; step();
   endtask

   task automatic test_snooze();
      refire();
      snooze = 1; step(); snooze = 0; step();
`ifdef ALARM_SNOOZE_EN
      checks++; if ({alarm_on, alarm_led, ringing} !== 3'b010) begin failures++;
         $display("FAIL snooze_enter: got %b want 010", {alarm_on, alarm_led, ringing}); end
      tick_n(SS - 1, 1);
      checks++; if ({alarm_on, alarm_led, ringing} !== 3'b010) begin failures++;
         $display("FAIL snooze_hold: got %b want 010", {alarm_on, alarm_led, ringing}); end
      sec_tick = 1; step(); sec_tick = 0; step();
      checks++; if ({alarm_on, alarm_led, ringing} !== 3'b111) begin failures++;
         $display("FAIL snooze_rering: got %b want 111", {alarm_on, alarm_led, ringing}); end
      dismiss = 1; snooze = 1; step(); dismiss = 0; snooze = 0; step();
      checks++; if ({alarm_on, alarm_led, ringing} !== 3'b000) begin failures++;
         $display("FAIL dismiss_beats_snooze: got %b want 000", {alarm_on, alarm_led, ringing}); end
`else
      checks++; if ({alarm_on, ringing} !== 2'b11) begin failures++;
         $display("FAIL snooze_ignored: got %b want 11", {alarm_on, ringing}); end
      dismiss = 1; step(); dismiss = 0; step();
      checks++; if ({alarm_on, alarm_led, ringing} !== 3'b000) begin failures++;
         $display("FAIL snooze_dismiss: got %b want 000", {alarm_on, alarm_led, ringing}); end
`endif
   endtask

   task automatic test_reset_mid();
      refire();
      rst = 1; step();
      checks++; if ({alarm_on, alarm_led, ringing} !== 3'b000) begin failures++;
         $display("FAIL reset_mid_ring: got %b want 000", {alarm_on, alarm_led, ringing}); end
      set_al(23, 59); set_clk(23, 58); step();
      rst = 0; step();
      checks++; if ({alarm_on, alarm_led, ringing} !== {e_on, e_led, e_ring}) begin failures++;
         $display("FAIL reset_mid_release: got %b want %b", {alarm_on, alarm_led, ringing}, {e_on, e_led, e_ring}); end
      set_clk(23, 59); step(); step();
      checks++; if ({alarm_on, alarm_led, ringing} !== 3'b111) begin failures++;
         $display("FAIL fire_2359: got %b want 111", {alarm_on, alarm_led, ringing}); end
      set_clk(0, 0); step(); step();
      checks++; if ({alarm_on, ringing} !== 2'b11 || ringing !== e_ring) begin failures++;
         $display("FAIL midnight_no_action: got %b want 11", {alarm_on, ringing}); end
      dismiss = 1; step(); dismiss = 0; step();
   endtask

   task automatic test_random();
      int sel;
      for (int i = 0; i < 4000; i++) begin
         rst          = ($urandom_range(0, 499) == 0);
         alarm_enable = ($urandom_range(0, 31) != 0);
         dismiss      = ($urandom_range(0, 63) == 0);
         snooze       = ($urandom_range(0, 31) == 0);
         sec_tick     = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) begin
            sel = $urandom_range(0, 4);
            case (sel)
               0, 1: {c_ht, c_hu, c_mt, c_mu} = {a_ht, a_hu, a_mt, a_mu};
               2: set_clk($urandom_range(0, 23), $urandom_range(0, 59));
               3: {c_ht, c_hu, c_mt, c_mu} = 13'($urandom);
               default: set_al($urandom_range(0, 23), $urandom_range(0, 59));
            endcase
         end
         step();
         checks++; if ({alarm_on, alarm_led, ringing} !== {e_on, e_led, e_ring}) begin failures++;
            $display("FAIL random_cycle %0d: got %b want %b", i, {alarm_on, alarm_led, ringing}, {e_on, e_led, e_ring}); end
      end
      rst = 0; dismiss = 0; snooze = 0; sec_tick = 0; alarm_enable = 1;
   endtask

   initial begin
      test_reset();
      test_fire();
      test_timeout();
      test_dismiss();
      test_enable();
      test_snooze();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
